// File: rtl/nap_timer_ctrl.sv
// Power-nap sequencer: arms the keypad, latches a clamped BCD duration, counts it down
// once per second and holds a self-expiring alarm.
module nap_timer_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int ALARM_SEC     = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       cancel,
   input  logic       completeSetting,
   input  logic [3:0] one_sec,
   input  logic [3:0] ten_sec,
   input  logic [3:0] one_min,
   output logic       keypad_en,
   output logic [3:0] rem_min,
   output logic [3:0] rem_ten,
   output logic [3:0] rem_one,
   output logic       running,
   output logic       alarm,
   output logic       done,
   output logic [1:0] state_dbg
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [AW-1:0] ASEC_LAST = AW'(ALARM_SEC - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] ALARM = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] presc;
   logic [AW-1:0] asec;
   logic [3:0]    c_one, c_ten, c_min;
   logic          tick;
   logic          last_sec;

   // Out-of-range keypad digits saturate to the largest legal BCD digit
   assign c_one = (one_sec > 4'd9) ? 4'd9 : one_sec;
   assign c_ten = (ten_sec > 4'd5) ? 4'd5 : ten_sec;
   assign c_min = (one_min > 4'd9) ? 4'd9 : one_min;

   assign tick     = (presc == PRESC_MAX);
   assign last_sec = (rem_min == 4'd0) && (rem_ten == 4'd0) && (rem_one == 4'd1);

   assign keypad_en = (state == SETUP);
   assign running   = (state == RUN);
   assign alarm     = (state == ALARM);
   assign state_dbg = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         presc   <= '0;
         asec    <= '0;
         rem_min <= 4'd0;
         rem_ten <= 4'd0;
         rem_one <= 4'd0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (!cancel && start) state <= SETUP;
            end
            SETUP: begin
               // start outranks completeSetting, so a held start defers the load
               if (cancel) begin
                  state <= IDLE;
               end else if (!start && completeSetting) begin
                  if ({c_min, c_ten, c_one} == 12'd0) begin
                     state <= IDLE;
                  end else begin
                     state   <= RUN;
                     rem_min <= c_min;
                     rem_ten <= c_ten;
                     rem_one <= c_one;
                     presc   <= '0;
                  end
               end
            end
            RUN: begin
               if (cancel) begin
                  state   <= IDLE;
                  presc   <= '0;
                  rem_min <= 4'd0;
                  rem_ten <= 4'd0;
                  rem_one <= 4'd0;
               end else begin
                  presc <= tick ? '0 : presc + PW'(1);
                  if (tick) begin
                     if (last_sec) begin
                        state   <= ALARM;
                        done    <= 1'b1;
                        rem_one <= 4'd0;
                     end else if (rem_one != 4'd0) begin
                        rem_one <= rem_one - 4'd1;
                     end else begin
                        rem_one <= 4'd9;
                        if (rem_ten != 4'd0) begin
                           rem_ten <= rem_ten - 4'd1;
                        end else begin
                           rem_ten <= 4'd5;
                           rem_min <= rem_min - 4'd1;
                        end
                     end
                  end
               end
            end
            ALARM: begin
               if (cancel || start) begin
                  state <= IDLE;
                  presc <= '0;
                  asec  <= '0;
               end else begin
                  presc <= tick ? '0 : presc + PW'(1);
                  if (tick) begin
                     if (asec == ASEC_LAST) begin
                        state <= IDLE;
                        presc <= '0;
                        asec  <= '0;
                     end else begin
                        asec <= asec + AW'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Bench for nap_timer_ctrl: directed scenarios plus random sessions, each cycle compared
// against a seconds-and-elapsed-cycles model of the timer.
module tb_nap_timer_ctrl;

   localparam int T  = 4;
   localparam int AS = 2;
   localparam int MI = 0, MS = 1, MR = 2, MA = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, cancel = 1'b0, completeSetting = 1'b0;
   logic [3:0] one_sec = 4'd0, ten_sec = 4'd0, one_min = 4'd0;
   logic       keypad_en, running, alarm, done;
   logic [3:0] rem_min, rem_ten, rem_one;
   logic [1:0] state_dbg;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;
   int m_mode, m_secs, m_cyc;
   bit m_done;
   int t_mode, t_secs, t_cyc;
   bit t_done;

   logic [15:0] dut_vec;
   assign dut_vec = {keypad_en, running, alarm, done, rem_min, rem_ten, rem_one};

   always #5 clock = ~clock;

   nap_timer_ctrl #(.TICKS_PER_SEC(T), .ALARM_SEC(AS)) dut (
      .clock(clock), .reset(reset), .start(start), .cancel(cancel),
      .completeSetting(completeSetting), .one_sec(one_sec), .ten_sec(ten_sec),
      .one_min(one_min), .keypad_en(keypad_en), .rem_min(rem_min), .rem_ten(rem_ten),
      .rem_one(rem_one), .running(running), .alarm(alarm), .done(done),
      .state_dbg(state_dbg)
   );

   // Reference: remaining time as whole seconds, progress as cycles elapsed in the state
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_mode <= MI; m_secs <= 0; m_cyc <= 0; m_done <= 1'b0;
      end else begin
         t_mode = m_mode; t_secs = m_secs; t_cyc = m_cyc; t_done = 1'b0;
         case (t_mode)
            MI: if (!cancel && start) t_mode = MS;
            MS: begin
               if (cancel) t_mode = MI;
               else if (!start && completeSetting) begin
                  t_secs = ((one_min > 9) ? 9 : int'(one_min)) * 60
                         + ((ten_sec > 5) ? 5 : int'(ten_sec)) * 10
                         + ((one_sec > 9) ? 9 : int'(one_sec));
                  if (t_secs == 0) t_mode = MI;
                  else begin t_mode = MR; t_cyc = 0; end
               end
            end
            MR: begin
               if (cancel) begin t_mode = MI; t_secs = 0; end
               else begin
                  t_cyc++;
                  if (t_cyc % T == 0) t_secs--;
                  if (t_secs == 0) begin t_mode = MA; t_done = 1'b1; t_cyc = 0; end
               end
            end
            default: begin
               if (cancel || start) t_mode = MI;
               else begin
                  t_cyc++;
                  if (t_cyc == AS * T) t_mode = MI;
               end
            end
         endcase
         m_mode <= t_mode; m_secs <= t_secs; m_cyc <= t_cyc; m_done <= t_done;
      end
   end

   always @(negedge clock) if (done === 1'b1) done_seen++;

   function automatic logic [15:0] exp_vec();
      return {m_mode == MS, m_mode == MR, m_mode == MA, m_done,
              4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
   endfunction

   task automatic set_digits(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
      one_min = m; ten_sec = t; one_sec = o;
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (dut_vec !== 16'd0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %h/%0d expected 0/0", dut_vec, state_dbg);
         end
      end
      reset = 1'b1;
      completeSetting = 1'b1; set_digits(4'd1, 4'd2, 4'd3);
      repeat (4) begin
         @(negedge clock);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL idle_ignore: got %h expected %h", dut_vec, exp_vec());
         end
      end
      completeSetting = 1'b0;
   endtask

   task automatic test_five_sec();
      int n, a, d0;
      d0 = done_seen;
      start = 1'b1;
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL five_setup: got %h expected %h", dut_vec, exp_vec()); end
      start = 1'b0; completeSetting = 1'b1; set_digits(4'd0, 4'd0, 4'd5);
      @(negedge clock);
      completeSetting = 1'b0;
      checks++;
      if (dut_vec !== 16'h4005) begin errors++; $display("FAIL five_load: got %h expected 4005", dut_vec); end
      n = 0;
      while (alarm !== 1'b1 && n < 100) begin
         @(negedge clock); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL five_run: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (n !== 5 * T) begin errors++; $display("FAIL five_alarm_latency: got %0d expected %0d", n, 5 * T); end
      a = 0;
      while (alarm === 1'b1 && a < 50) begin
         a++; @(negedge clock);
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL five_alarm: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (a !== AS * T) begin errors++; $display("FAIL five_alarm_len: got %0d expected %0d", a, AS * T); end
      checks++;
      if (done_seen - d0 !== 1) begin errors++; $display("FAIL five_done_count: got %0d expected 1", done_seen - d0); end
   endtask

   task automatic test_one_minute();
      int n;
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd1, 4'd0, 4'd0);
      @(negedge clock); completeSetting = 1'b0;
      n = 0;
      while (alarm !== 1'b1 && n < 400) begin
         @(negedge clock); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL min_run: got %h expected %h", dut_vec, exp_vec()); end
         if (n == T) begin
            checks++;
            if ({rem_min, rem_ten, rem_one} !== 12'h059) begin
               errors++; $display("FAIL min_first_tick: got %h expected 059", {rem_min, rem_ten, rem_one});
            end
         end
      end
      checks++;
      if (n !== 60 * T) begin errors++; $display("FAIL min_alarm_latency: got %0d expected %0d", n, 60 * T); end
      cancel = 1'b1; @(negedge clock); cancel = 1'b0;
      checks++;
      if (alarm !== 1'b0) begin errors++; $display("FAIL min_cancel_alarm: got %b expected 0", alarm); end
   endtask

   task automatic test_clamp();
      int d0;
      d0 = done_seen;
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd0, 4'd0, 4'd0);
      @(negedge clock); completeSetting = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (dut_vec !== 16'd0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL zero_set: got %h/%0d expected 0/0", dut_vec, state_dbg);
         end
      end
      checks++;
      if (done_seen !== d0) begin errors++; $display("FAIL zero_done: got %0d expected %0d", done_seen, d0); end
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd0, 4'd7, 4'd12);
      @(negedge clock); completeSetting = 1'b0; set_digits(4'd9, 4'd9, 4'd9);
      checks++;
      if ({running, rem_min, rem_ten, rem_one} !== 13'h1059) begin
         errors++; $display("FAIL clamp_load: got %h expected 1059", {running, rem_min, rem_ten, rem_one});
      end
      cancel = 1'b1; @(negedge clock); cancel = 1'b0;
   endtask

   task automatic test_cancel_tick();
      int n, d0;
      bit fired;
      d0 = done_seen; fired = 1'b0;
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd0, 4'd0, 4'd3);
      @(negedge clock); completeSetting = 1'b0;
      n = 0;
      while (!fired && n < 40) begin
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL cancel_run: got %h expected %h", dut_vec, exp_vec()); end
         start = (n == 1 || n == 6);
         if (m_mode == MR && m_secs == 2 && (m_cyc + 1) % T == 0) begin
            cancel = 1'b1; fired = 1'b1;
         end
         @(negedge clock); n++;
      end
      cancel = 1'b0; start = 1'b0;
      checks++;
      if (!fired || {keypad_en, running, alarm, rem_min, rem_ten, rem_one} !== 15'd0) begin
         errors++; $display("FAIL cancel_tick: got %h expected 0", {keypad_en, running, alarm, rem_min, rem_ten, rem_one});
      end
      repeat (2) @(negedge clock);
      checks++;
      if (done_seen !== d0) begin errors++; $display("FAIL cancel_done: got %0d expected %0d", done_seen, d0); end
   endtask

   task automatic test_alarm_ack();
      int n, d0;
      d0 = done_seen;
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd0, 4'd0, 4'd1);
      @(negedge clock); completeSetting = 1'b0;
      n = 0;
      while (alarm !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      checks++;
      if (alarm !== 1'b1) begin errors++; $display("FAIL ack_alarm_rise: got %b expected 1", alarm); end
      repeat (2) @(negedge clock);
      start = 1'b1;
      @(negedge clock); start = 1'b0;
      checks++;
      if (alarm !== 1'b0 || state_dbg !== 2'd0) begin
         errors++; $display("FAIL ack_start: got %b/%0d expected 0/0", alarm, state_dbg);
      end
      repeat (10) @(negedge clock);
      checks++;
      if (done_seen - d0 !== 1) begin errors++; $display("FAIL ack_done_count: got %0d expected 1", done_seen - d0); end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; @(negedge clock); start = 1'b0;
      completeSetting = 1'b1; set_digits(4'd0, 4'd0, 4'd3);
      @(negedge clock); completeSetting = 1'b0;
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (dut_vec !== 16'd0 || state_dbg !== 2'd0) begin
         errors++; $display("FAIL reset_async: got %h/%0d expected 0/0", dut_vec, state_dbg);
      end
      @(negedge clock); reset = 1'b1;
      completeSetting = 1'b1; set_digits(4'd0, 4'd3, 4'd3);
      repeat (4) begin
         @(negedge clock);
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", dut_vec, exp_vec()); end
      end
      completeSetting = 1'b0; start = 1'b1;
      @(negedge clock); start = 1'b0;
      checks++;
      if (keypad_en !== 1'b1) begin errors++; $display("FAIL post_reset_start: got %b expected 1", keypad_en); end
      cancel = 1'b1; @(negedge clock); cancel = 1'b0;
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 12; it++) begin
         start = 1'b1; @(negedge clock); start = 1'b0;
         completeSetting = 1'b1;
         set_digits(4'd0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         @(negedge clock); completeSetting = 1'b0;
         n = 0;
         while (m_mode != MI && n < 300) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_cycle: got %h expected %h", dut_vec, exp_vec()); end
            cancel = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 59) == 0);
            completeSetting = ($urandom_range(0, 9) == 0);
            set_digits(4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            @(negedge clock); n++;
         end
         cancel = 1'b1; start = 1'b0; completeSetting = 1'b0;
         @(negedge clock); cancel = 1'b0;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_end: got %h expected %h", dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_five_sec();
      test_one_minute();
      test_clamp();
      test_cancel_tick();
      test_alarm_ack();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
